// File: rtl/median_pkg.sv
// median_pkg: shared constants, pixel type and window index helper for the median filter datapath
package median_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int ELEMENT_NUM = KERNEL_SIZE * KERNEL_SIZE;
  typedef logic [DATA_WIDTH-1:0] pixel_t;
  function automatic int win_idx(input int wr, input int wc);
    return KERNEL_SIZE * wr + wc;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: single-port read-before-write line store, one pixel per column
module line_buffer
  import median_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  pixel_t mem_q [DEPTH];
  assign rdata = mem_q[addr];
  // store the incoming pixel after the old one at this column has been read out
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/median_window_gen.sv
// median_window_gen: streaming 5x5 window generator over four chained line buffers; MEDIAN_BORDER_FLAG_EN adds border windows with zero padding
module median_window_gen
  import median_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int AW = $clog2(IMG_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sof,
  input  logic                              pixel_valid,
  input  logic [DATA_WIDTH-1:0]             pixel_in,
  output logic [DATA_WIDTH*ELEMENT_NUM-1:0] window,
  output logic                              window_valid
`ifdef MEDIAN_BORDER_FLAG_EN
  ,
  output logic                              window_border
`endif
);
  localparam int LAST = KERNEL_SIZE - 1;
  logic                              start, wrap, interior, valid_d, border_d;
  logic [AW-1:0]                     col_q, col_d, col_eff;
  logic [2:0]                        row_q, row_d, row_eff;
  pixel_t                            lb_rd [LAST];
  pixel_t                            lb_wd [LAST];
  pixel_t                            new_col [KERNEL_SIZE];
  pixel_t                            win_q [ELEMENT_NUM];
  pixel_t                            win_d [ELEMENT_NUM];
  logic [DATA_WIDTH*ELEMENT_NUM-1:0] window_q, window_d;
  logic                              valid_q, border_q;
  // position of the pixel being accepted; sof restarts it at (0,0), row saturates once four lines are stored
  always_comb begin
    start = sof && pixel_valid;
    col_eff = start ? '0 : col_q;
    row_eff = start ? '0 : row_q;
    wrap = col_eff == AW'(IMG_WIDTH - 1);
    col_d = !pixel_valid ? col_q : wrap ? '0 : col_eff + 1'b1;
    row_d = !pixel_valid ? row_q : (wrap && row_eff != 3'd4) ? row_eff + 3'd1 : row_eff;
  end
  // buffer 0 takes the live pixel, each later buffer takes what the previous one just read out
  always_comb begin
    lb_wd[0] = pixel_in;
    for (int k = 1; k < LAST; k++) lb_wd[k] = lb_rd[k-1];
  end
  for (genvar k = 0; k < LAST; k++) begin : g_lb
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb (
      .clk  (clk),
      .we   (pixel_valid),
      .addr (col_eff),
      .wdata(lb_wd[k]),
      .rdata(lb_rd[k])
    );
  end
  // shift every window row left and append the column {r-4 .. r} at the current column
  always_comb begin
    new_col[LAST] = pixel_in;
    for (int wr = 0; wr < LAST; wr++) new_col[wr] = lb_rd[LAST-1-wr];
    win_d = win_q;
    for (int wr = 0; wr < KERNEL_SIZE; wr++) begin
      for (int wc = 0; wc < LAST; wc++)
        win_d[win_idx(wr, wc)] = pixel_valid ? win_q[win_idx(wr, wc+1)] : win_q[win_idx(wr, wc)];
      win_d[win_idx(wr, LAST)] = pixel_valid ? new_col[wr] : win_q[win_idx(wr, LAST)];
    end
  end
  // pack the next window for output; border builds zero every element that falls outside the image
  always_comb begin
    interior = row_eff == 3'd4 && col_eff >= AW'(LAST);
    window_d = window_q;
    for (int wr = 0; wr < KERNEL_SIZE; wr++)
      for (int wc = 0; wc < KERNEL_SIZE; wc++)
`ifdef MEDIAN_BORDER_FLAG_EN
        if (pixel_valid)
          window_d[win_idx(wr, wc)*DATA_WIDTH +: DATA_WIDTH] =
            (wr + int'(row_eff) < LAST || wc + int'(col_eff) < LAST) ? '0 : win_d[win_idx(wr, wc)];
`else
        if (pixel_valid) window_d[win_idx(wr, wc)*DATA_WIDTH +: DATA_WIDTH] = win_d[win_idx(wr, wc)];
`endif
`ifdef MEDIAN_BORDER_FLAG_EN
    valid_d = pixel_valid;
`else
    valid_d = pixel_valid && interior;
`endif
    border_d = pixel_valid ? !interior : border_q;
  end
  // counters, window shift register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      window_q <= '0;
      valid_q <= 1'b0;
      border_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      window_q <= window_d;
      valid_q <= valid_d;
      border_q <= border_d;
    end
  end
  assign window = window_q;
  assign window_valid = valid_q;
`ifdef MEDIAN_BORDER_FLAG_EN
  assign window_border = border_q;
`else
  logic unused_border;
  assign unused_border = border_q;
`endif
endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: randomized scoreboard bench for the 5x5 window generator against an image-array reference
module tb_median_window_gen;
  localparam int W = 8;
  localparam int DW = 8;
  localparam int EN = 25;
  localparam int LW = DW * EN;
`ifdef MEDIAN_BORDER_FLAG_EN
  localparam int FRAME_STROBES = 64;
`else
  localparam int FRAME_STROBES = 16;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic pixel_valid = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic [LW-1:0] window;
  logic window_valid;
  logic border_obs;
`ifdef MEDIAN_BORDER_FLAG_EN
  logic window_border;
  assign border_obs = window_border;
`else
  assign border_obs = 1'b0;
`endif
  median_window_gen #(.IMG_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sof         (sof),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .window      (window),
`ifdef MEDIAN_BORDER_FLAG_EN
    .window_border(window_border),
`endif
    .window_valid(window_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         cyc;
    logic [LW-1:0] win;
    logic       border;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [LW-1:0] log_q[$];
  logic log_b[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int strobes = 0, consec = 0;
  logic prev_valid = 1'b0;
  int img[8][W];
  int mr = 0, mc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [8:0] elem(input int idx, input int el);
    if (idx < 0 || idx >= log_q.size()) return 9'h1ff;
    return {1'b0, log_q[idx][el*DW +: DW]};
  endfunction
  function automatic logic [1:0] bord(input int idx);
    if (idx < 0 || idx >= log_b.size()) return 2'b11;
    return {1'b0, log_b[idx]};
  endfunction
  // reference: the frame as a 2-D image; a window is just the 5x5 patch ending at (r,c)
  task automatic model(input logic s, input logic v, input logic [DW-1:0] p);
    exp_t x;
    if (!v) return;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr%8][mc] = int'(p);
    x.cyc = cyc + 1;
    x.border = mr < 4 || mc < 4;
    x.win = '0;
    for (int wr = 0; wr < 5; wr++)
      for (int wc = 0; wc < 5; wc++)
        if (mr - 4 + wr >= 0 && mc - 4 + wc >= 0)
          x.win[(5*wr+wc)*DW +: DW] = DW'(img[(mr-4+wr)%8][mc-4+wc]);
`ifdef MEDIAN_BORDER_FLAG_EN
    exp_q.push_back(x);
`else
    if (!x.border) exp_q.push_back(x);
`endif
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
    end
  endtask
  task automatic px(input logic s, input logic v, input logic [DW-1:0] p);
    @(negedge clk);
    sof = s;
    pixel_valid = v;
    pixel_in = p;
    model(s, v, p);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'($urandom), 1'b0, DW'($urandom));
  endtask
  task automatic frame(input logic toggle);
    for (int i = 0; i < 64; i++) begin
      px(i == 0, 1'b1, DW'(i));
      if (toggle) idle(1);
    end
  endtask
  task automatic start_test();
    strobes = 0;
    consec = 0;
    log_q.delete();
    log_b.delete();
  endtask
  always @(negedge clk) begin
    if (window_valid === 1'b1) begin
      strobes++;
      if (prev_valid) consec++;
      log_q.push_back(window);
      log_b.push_back(border_obs);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got window_valid=1 at cycle %0d expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", LW'(cyc), LW'(e.cyc));
        chk("window", window, e.win);
`ifdef MEDIAN_BORDER_FLAG_EN
        chk("window_border", LW'(window_border), LW'(e.border));
`endif
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_strobe: got window_valid=%b at cycle %0d expected 1", window_valid, e.cyc);
    end
    prev_valid = window_valid === 1'b1;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int len;
    logic v;
    repeat (3) @(negedge clk);
    chk("reset_window", window, '0);
    chk("reset_valid", LW'(window_valid), '0);
    chk("reset_border", LW'(border_obs), '0);
    rst = 1'b0;
    // continuous 8x8 ramp
    start_test();
    frame(1'b0);
    idle(3);
    chk("t1_strobes", LW'(strobes), LW'(FRAME_STROBES));
`ifdef MEDIAN_BORDER_FLAG_EN
    chk("t1_b00_border", LW'(bord(0)), LW'(1));
    for (int i = 0; i < 25; i++) chk("t1_b00_elem", LW'(elem(0, i)), '0);
    chk("t1_b15_border", LW'(bord(13)), LW'(1));
    for (int i = 0; i < 15; i++) chk("t1_b15_upper", LW'(elem(13, i)), '0);
    chk("t1_b15_e24", LW'(elem(13, 24)), LW'(13));
    chk("t1_b44_border", LW'(bord(36)), LW'(0));
    chk("t1_b44_e0", LW'(elem(36, 0)), LW'(0));
    chk("t1_b44_e12", LW'(elem(36, 12)), LW'(18));
    chk("t1_last_e0", LW'(elem(63, 0)), LW'(27));
    chk("t1_last_e24", LW'(elem(63, 24)), LW'(63));
`else
    chk("t1_first_e0", LW'(elem(0, 0)), LW'(0));
    chk("t1_first_e12", LW'(elem(0, 12)), LW'(18));
    chk("t1_first_e24", LW'(elem(0, 24)), LW'(36));
    chk("t1_last_e0", LW'(elem(15, 0)), LW'(27));
    chk("t1_last_e24", LW'(elem(15, 24)), LW'(63));
`endif
    // line wrap into a ninth line: columns 0..3 never form interior windows
    start_test();
    for (int i = 0; i < 4; i++) px(1'b0, 1'b1, DW'(64 + i));
    idle(3);
`ifdef MEDIAN_BORDER_FLAG_EN
    chk("wrap_strobes", LW'(strobes), LW'(4));
`else
    chk("wrap_strobes", LW'(strobes), LW'(0));
`endif
    // same ramp with pixel_valid toggling and sof noise on idle cycles
    start_test();
    frame(1'b1);
    idle(3);
    chk("t2_strobes", LW'(strobes), LW'(FRAME_STROBES));
    chk("t2_consecutive", LW'(consec), '0);
    // partial frame then mid-frame sof with a fresh ramp
    start_test();
    for (int i = 0; i < 20; i++) px(i == 0, 1'b1, DW'($urandom));
    frame(1'b0);
    idle(3);
`ifdef MEDIAN_BORDER_FLAG_EN
    chk("t3_strobes", LW'(strobes), LW'(84));
`else
    chk("t3_strobes", LW'(strobes), LW'(16));
    chk("t3_first_e0", LW'(elem(0, 0)), LW'(0));
    chk("t3_first_e12", LW'(elem(0, 12)), LW'(18));
`endif
    // reset mid-frame, with sof and a valid pixel presented during reset
    for (int i = 0; i < 45; i++) px(i == 0, 1'b1, DW'($urandom));
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    sof = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = DW'($urandom);
    exp_q.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    rst = 1'b0;
    sof = 1'b0;
    pixel_valid = 1'b0;
    chk("t4_post_rst_valid", LW'(window_valid), '0);
    chk("t4_post_rst_window", window, '0);
    chk("t4_post_rst_border", LW'(border_obs), '0);
    start_test();
    frame(1'b0);
    idle(3);
    chk("t4_strobes", LW'(strobes), LW'(FRAME_STROBES));
    // random pixels, random valid density, random frame lengths and sof points
    start_test();
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(30, 140);
      for (int i = 0; i < len; i++) begin
        v = ($urandom % 4) != 0;
        px(i == 0 || ($urandom % 60) == 0, v, DW'($urandom));
      end
    end
    idle(3);
    chk("scoreboard_drained", LW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/median_window_gen.md
# median_window_gen

Streaming 5x5 window generator that feeds the median filter core. Accepts one raster-order pixel per valid cycle, keeps the previous four image lines in line buffers, and emits the packed 25-pixel window vector (same packing as the median core's `pixels` input) together with a qualifying strobe. It sits between the video input stage and the median core; together they form the filter datapath.

## Interface

- `DATA_WIDTH`, 8: bits per pixel
- `KERNEL_SIZE`, 5: window edge length; fixed at 5 in this block
- `ELEMENT_NUM`, 25: `KERNEL_SIZE*KERNEL_SIZE`; width of the packed window in pixels
- `IMG_WIDTH`, 640: pixels per line; legal range 5..4096
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sof`  in  1  start of frame; qualified by `pixel_valid`; marks pixel (0,0)
- `pixel_valid`  in  1  `pixel_in` carries a pixel this cycle
- `pixel_in`  in  DATA_WIDTH  raster-order pixel
- `window`  out  DATA_WIDTH*ELEMENT_NUM  packed window; element e at bits `[e*DATA_WIDTH +: DATA_WIDTH]`
- `window_valid`  out  1  `window` is valid this cycle; one-cycle strobe per window
- `window_border`  out  1  only with `MEDIAN_BORDER_FLAG_EN`; window touches outside the image

## Operation

- Counters: `col` (0..IMG_WIDTH-1, wraps to 0 and increments `row`); `row` saturates at 4. Both advance only on accepted pixels (`pixel_valid`=1).
- `sof`=1 with `pixel_valid`=1: the accepted pixel is (0,0); `col` and `row` restart from that pixel. `sof` without `pixel_valid` is ignored.
- Four line buffers, depth IMG_WIDTH, read-before-write at address `col`; buffer k outputs the pixel from line r-1-k at the same column, then stores its input (chained: buffer 0 takes `pixel_in`, buffer k takes buffer k-1's read data).
- 5x5 shift-register window: on each accepted pixel, every row shifts left by one column; the new rightmost column is {line r-4, r-3, r-2, r-1, r} at column c.
- Element index e = 5*wr + wc; wr=0 is the oldest line (r-4), wc=0 is the oldest column (c-4). Element 12 is the centre pixel (r-2, c-2).
- The window produced by accepted pixel (r,c) is complete when r≥4 and c≥4 (interior). Interior windows assert `window_valid`.
- No acceptance without `pixel_valid`: the window, counters, and buffers hold. `window_valid` is 0 on every cycle that follows a non-accepting cycle.
- Across a line wrap, the window keeps stale columns from the previous line. These are harmless because c<4 is never interior.
- Reset: `col`=0, `row`=0, `window` all zero, `window_valid`=0, `window_border`=0. Line buffer contents are not cleared; `row`<4 masking makes them irrelevant.
- Reset has priority over `sof`, `pixel_valid`, and the mid-frame state. The first frame after reset needs `sof`; pixels before it count from (0,0).

## Timing

- Latency: `window`/`window_valid` register one cycle after the accepting cycle of pixel (r,c).
- Throughput: one window per clock at sustained `pixel_valid`. No backpressure; downstream always accepts.
- The line buffer read is combinational or one-cycle pipelined internally, but the external latency is exactly 1 cycle.
- Per frame of H lines: (IMG_WIDTH-4)*(H-4) `window_valid` strobes without the macro.

## Configuration

- `MEDIAN_BORDER_FLAG_EN` undefined:
  - only interior windows assert `window_valid`
  - `window_border` port is absent
- `MEDIAN_BORDER_FLAG_EN` defined:
  - `window_valid` pulses for every accepted pixel
  - `window_border`=1 when r<4 or c<4
  - window elements outside the image (line < 0, or column < 0 within the current line) are forced to zero
  - interior windows behave identically to the non-macro build
  - `window_border` resets to 0

## Structure

- Shared package `median_pkg`:
  - `DATA_WIDTH`, `KERNEL_SIZE`, `ELEMENT_NUM` constants
  - `pixel_t` typedef
  - function `win_idx(wr,wc)` = 5*wr+wc
- Sub-module `line_buffer`:
  - single-port RAM, depth IMG_WIDTH, width DATA_WIDTH, read-before-write
  - instantiated four times in a chain
- Top level holds the counters, the window shift register, and output registers. Expected size 150–250 lines.

## Test plan

- IMG_WIDTH=8, 8x8 frame, pixel = 8r+c, continuous valid, `sof` on first pixel:
  - first `window_valid` occurs 1 cycle after pixel (4,4) (the 37th pixel)
  - element 0 = 0, element 12 = 18, element 24 = 36
  - 16 strobes total
- Same frame with `pixel_valid` toggling 1,0,1,0:
  - identical window sequence and values
  - `window_valid` never on two consecutive cycles
- Mid-frame `sof` at pixel index 20 of frame 1, then a fresh 8x8 ramp:
  - first strobe after (4,4) of the new frame, element 0 = 0
  - no strobes from partial frame 1 after `sof`
- Assert `rst` for 1 cycle mid-frame:
  - next cycle `window_valid`=0 and `window`=0
  - a subsequent full frame gives the same 16 windows as test 1
- Last interior window of test 1:
  - element 0 = 27 (3,3), element 24 = 63 (7,7)
  - no strobe after the next line wrap
- With `MEDIAN_BORDER_FLAG_EN`, test 1 stimulus:
  - 64 strobes
  - pixel (0,0) window: `window_border`=1, elements 0–23 = 0, element 24 = 0
  - pixel (1,5) window: `window_border`=1, rows wr=0..2 zero, element 24 = 13
  - pixel (4,4): `window_border`=0
